udp_tx_arbiter: RTL

- Packet-granular round-robin arbiter that shares the single 8-bit UDP TX AXI-Stream path between NUM_SRC byte-stream requesters (e.g. the UDP loopback buffer and a local packet generator).
- Once a source is granted, it holds the output until its tlast beat is accepted. No packet interleaving.
- Enforces a maximum payload length: over-long packets are truncated with a forced tlast, and the tail of the packet is drained.

---
 rtl/udp_tx_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: packet-granular round-robin arbiter for the 8-bit UDP TX stream.
// Over-long packets are cut at MAX_PKT_LEN with a forced tlast and their tail drained.
module udp_tx_arbiter #(
    parameter int NUM_SRC     = 2,
    parameter int MAX_PKT_LEN = 1472,
    parameter int CNT_W       = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SRC*8-1:0]   s_axis_tdata_in,
    input  logic [NUM_SRC-1:0]     s_axis_tvalid_in,
    input  logic [NUM_SRC-1:0]     s_axis_tlast_in,
    output logic [NUM_SRC-1:0]     s_axis_tready_out,
    output logic [7:0]             udp_axis_tdata_out,
    output logic                   udp_axis_tvalid_out,
    output logic                   udp_axis_tlast_out,
    input  logic                   udp_axis_tready_in,
    output logic [NUM_SRC-1:0]     grant_out,
    output logic                   busy_out,
    output logic [15:0]            trunc_cnt_out
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_PKT_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SRC - 1);
    localparam logic [IDX_W:0]   NSRC_W   = (IDX_W + 1)'(NUM_SRC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] pick;
    logic [IDX_W:0]   cand;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      trunc_q, trunc_d;
    logic             src_vld;
    logic             src_last;
    logic             at_max;
    logic             pass_acc;

    assign src_vld       = s_axis_tvalid_in[gnt_q];
    assign src_last      = s_axis_tlast_in[gnt_q];
    assign at_max        = (cnt_q == CNT_LAST);
    assign pass_acc      = src_vld & udp_axis_tready_in;
    assign trunc_cnt_out = trunc_q;

    // Round-robin search: nearest requester after the last granted source wins
    always_comb begin
        pick = last_q;
        cand = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            cand = {1'b0, last_q} + (IDX_W + 1)'(k);
            if (cand >= NSRC_W) begin
                cand = cand - NSRC_W;
            end
            if (s_axis_tvalid_in[cand[IDX_W-1:0]]) begin
                pick = cand[IDX_W-1:0];
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant, round-robin pointer, beat counter and truncation statistics
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_q   <= '0;
            last_q  <= IDX_LAST;
            cnt_q   <= '0;
            trunc_q <= '0;
        end else begin
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            trunc_q <= trunc_d;
        end
    end

    // Next-state: source tlast ends a packet before the length limit is considered
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        trunc_d = trunc_q;
        unique case (state_q)
            IDLE: begin
                if (|s_axis_tvalid_in) begin
                    gnt_d   = pick;
                    state_d = PASS;
                end
            end
            PASS: begin
                if (pass_acc) begin
                    if (src_last) begin
                        cnt_d   = '0;
                        last_d  = gnt_q;
                        state_d = IDLE;
                    end else if (at_max) begin
                        cnt_d   = '0;
                        last_d  = gnt_q;
                        state_d = DROP;
                        if (trunc_q != 16'hFFFF) begin
                            trunc_d = trunc_q + 16'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DROP: begin
                if (src_vld && src_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: combinational pass-through in PASS, silent sink in DROP
    always_comb begin
        s_axis_tready_out   = '0;
        udp_axis_tdata_out  = '0;
        udp_axis_tvalid_out = 1'b0;
        udp_axis_tlast_out  = 1'b0;
        grant_out           = '0;
        busy_out            = 1'b0;
        unique case (state_q)
            PASS: begin
                grant_out[gnt_q]         = 1'b1;
                busy_out                 = 1'b1;
                udp_axis_tdata_out       = s_axis_tdata_in[{gnt_q, 3'b000} +: 8];
                udp_axis_tvalid_out      = src_vld;
                udp_axis_tlast_out       = src_last | at_max;
                s_axis_tready_out[gnt_q] = udp_axis_tready_in;
            end
            DROP: begin
                grant_out[gnt_q]         = 1'b1;
                busy_out                 = 1'b1;
                s_axis_tready_out[gnt_q] = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
